svc_axi_sram_if: RTL
====================

# svc_axi_sram_if

AXI4 slave front end that turns AXI read and write bursts into the single-word `sram_cmd` / `sram_resp` stream consumed by the ice40 SRAM IO interface stage.
- Arbitrates between the AR and AW channels, issues one SRAM command per beat with word-granular incrementing addresses, and builds the B and R response channels.
- Sits directly upstream of the SRAM IO interface stage; one instance per SRAM chip or stripe.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, default 20: byte address width.
- `AXI_DATA_WIDTH`, default 16: data width; must be a power of 2, at least 8.
- `AXI_STRB_WIDTH`, default `AXI_DATA_WIDTH/8`: write strobe width.
- `AXI_ID_WIDTH`, default 4: transaction ID width.
- `SRAM_ADDR_WIDTH`, default `AXI_ADDR_WIDTH - $clog2(AXI_STRB_WIDTH)`: word address width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- AW channel: `s_axi_awvalid`/`s_axi_awready` (in/out, 1), `s_axi_awaddr` (in, AXI_ADDR_WIDTH), `s_axi_awid` (in, AXI_ID_WIDTH), `s_axi_awlen` (in, 8), `s_axi_awsize` (in, 3), `s_axi_awburst` (in, 2).
- W channel: `s_axi_wvalid`/`s_axi_wready` (in/out, 1), `s_axi_wdata` (in, AXI_DATA_WIDTH), `s_axi_wstrb` (in, AXI_STRB_WIDTH), `s_axi_wlast` (in, 1).
- B channel: `s_axi_bvalid`/`s_axi_bready` (out/in, 1), `s_axi_bid` (out, AXI_ID_WIDTH), `s_axi_bresp` (out, 2).
- AR channel: `s_axi_arvalid`/`s_axi_arready` (in/out, 1), `s_axi_araddr` (in, AXI_ADDR_WIDTH), `s_axi_arid` (in, AXI_ID_WIDTH), `s_axi_arlen` (in, 8), `s_axi_arsize` (in, 3), `s_axi_arburst` (in, 2).
- R channel: `s_axi_rvalid`/`s_axi_rready` (out/in, 1), `s_axi_rid` (out, AXI_ID_WIDTH), `s_axi_rdata` (out, AXI_DATA_WIDTH), `s_axi_rresp` (out, 2), `s_axi_rlast` (out, 1).
- SRAM command: `sram_cmd_valid` (out, 1), `sram_cmd_ready` (in, 1), `sram_cmd_addr` (out, SRAM_ADDR_WIDTH), `sram_cmd_wr_en` (out, 1), `sram_cmd_wr_data` (out, AXI_DATA_WIDTH), `sram_cmd_wr_strb` (out, AXI_STRB_WIDTH).
- SRAM response: `sram_resp_rd_valid` (in, 1), `sram_resp_rd_ready` (out, 1), `sram_resp_rd_data` (in, AXI_DATA_WIDTH).

## Operation
- FSM states: IDLE, READ, WRITE. Reset puts it in IDLE.
- IDLE:
  - Grant AR if `arvalid && !r_busy`.
  - Grant AW if `awvalid && !bvalid`.
  - If both are eligible, the arbiter picks one (see Configuration).
  - `arready`/`awready` are high only in IDLE, on the granted channel.
  - On the accept cycle, register the word address (`addr >> $clog2(AXI_STRB_WIDTH)`), the beat count (`len`), and the ID. Next state is READ or WRITE.
- READ:
  - `sram_cmd_valid=1`, `wr_en=0`.
  - Each `sram_cmd` handshake increments the address; when the last beat handshakes, next state is IDLE.
  - AR accept sets `r_busy` and loads the R beat counter with `arlen` and `rid`.
- R path (combinational pass-through, gated by `r_busy`):
  - `rvalid = sram_resp_rd_valid && r_busy`; `sram_resp_rd_ready = rready && r_busy`; `rdata = sram_resp_rd_data`.
  - `rlast` is high when the R beat counter is 0; the counter decrements on each R handshake.
  - `r_busy` clears on the `rlast` handshake, so at most one read burst is outstanding.
- WRITE:
  - `sram_cmd_valid = wvalid`, `wready = sram_cmd_ready`; wdata and wstrb pass straight through.
  - The internal beat counter is authoritative; `wlast` is ignored.
  - On the last beat handshake: next state is IDLE, `bvalid` is set next cycle with the registered `bid`, and it is held until `bready`.
- `bresp` and `rresp` are always OKAY (0). Burst type and size are not checked; all bursts are treated as INCR at full width.
- The word address wraps modulo `2^SRAM_ADDR_WIDTH`. Unaligned low address bits are dropped.
- A write and a read never overlap in the SRAM command stream. Read commands may still have responses in flight while a write burst is issued.

## Timing
- Reset values: all `*ready` = 0, `bvalid`/`rvalid` = 0, `sram_cmd_valid` = 0, `rlast` = 0, `bresp`/`rresp` = 0, `r_busy` = 0, state = IDLE.
- AR/AW accept to first `sram_cmd_valid`: 1 cycle.
- Back-to-back beats issue every cycle while `sram_cmd_ready` is high.
- Minimum gap between bursts is one IDLE cycle.
- `sram_cmd_*` must stay stable while `valid && !ready`. Address and wr_en are registered; the write data stability follows the AXI W stability rule.
- Last write beat handshake to `bvalid`: 1 cycle.
- Reset mid-burst abandons all state with no responses; upstream resets with this block.

## Configuration
- `SVC_AXI_SRAM_IF_RR_ARB_EN`:
  - Defined: round-robin. A 1-bit last-grant register favours the channel not granted most recently; its reset value favours read.
  - Undefined: fixed read priority. AW is granted only when no AR is eligible.

## Test plan
- AW addr 0x20, len 0, wdata 0xBEEF, strb 0b11 -> `sram_cmd` addr 0x10, `wr_en=1`, data 0xBEEF. Then `bvalid`, bid echoed, bresp 0.
- AR addr 0x20, len 3, `sram_resp` returns 1, 2, 3, 4 -> 4 commands at addr 0x10–0x13 on consecutive cycles; `rdata` 1..4; `rlast` only on beat 4; rid echoed.
- AR and AW both valid every burst, 4 bursts -> with macro: R, W, R, W grant order. Without macro: all reads first.
- `rready` held low 10 cycles during a 4-beat read -> `rvalid` is held with stable data; no second AR is accepted until `rlast` handshakes.
- AR addr at the top word, len 1 -> second command addr 0 (wrap). `sram_cmd_ready` low for 3 cycles -> addr/wr_en stable.
- `rst_n` low during beat 2 of a write burst -> next cycle all outputs at reset values; FSM in IDLE; a new AW is accepted.

Source files
------------

// File: rtl/svc_axi_sram_if.sv
// rtl/svc_axi_sram_if.sv - AXI4 slave to single-word SRAM command/response stream.
// Optional SVC_AXI_SRAM_IF_RR_ARB_EN selects round-robin AR/AW arbitration (default: read priority).
module svc_axi_sram_if #(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH - $clog2(AXI_STRB_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_awid,
  input  logic [7:0]                 s_axi_awlen,
  input  logic [2:0]                 s_axi_awsize,
  input  logic [1:0]                 s_axi_awburst,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0]  s_axi_wstrb,
  input  logic                       s_axi_wlast,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]    s_axi_bid,
  output logic [1:0]                 s_axi_bresp,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       sram_cmd_valid,
  input  logic                       sram_cmd_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_cmd_addr,
  output logic                       sram_cmd_wr_en,
  output logic [AXI_DATA_WIDTH-1:0]  sram_cmd_wr_data,
  output logic [AXI_STRB_WIDTH-1:0]  sram_cmd_wr_strb,
  input  logic                       sram_resp_rd_valid,
  output logic                       sram_resp_rd_ready,
  input  logic [AXI_DATA_WIDTH-1:0]  sram_resp_rd_data
);
  localparam int LSB = $clog2(AXI_STRB_WIDTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                     state, state_next;
  logic [SRAM_ADDR_WIDTH-1:0] addr;
  logic [7:0]                 beat_cnt;
  logic [AXI_ID_WIDTH-1:0]    bid_q, rid_q;
  logic                       r_busy;
  logic [7:0]                 r_cnt;
  logic                       bvalid_q;
  logic                       ar_elig, aw_elig, grant_ar, grant_aw;
  logic                       cmd_hs, r_hs;

  // Burst type, size and wlast carry no information for this block.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst, s_axi_wlast};

  assign ar_elig = (state == IDLE) && s_axi_arvalid && !r_busy;
  assign aw_elig = (state == IDLE) && s_axi_awvalid && !bvalid_q;

`ifdef SVC_AXI_SRAM_IF_RR_ARB_EN
  logic last_rd;

  always_comb begin
    grant_ar = ar_elig;
    if (ar_elig && aw_elig) grant_ar = !last_rd;
    grant_aw = aw_elig && !grant_ar;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_rd <= 1'b0;
    else if (grant_ar || grant_aw) last_rd <= grant_ar;
  end
`else
  assign grant_ar = ar_elig;
  assign grant_aw = aw_elig && !ar_elig;
`endif

  always_comb begin
    state_next     = state;
    s_axi_arready  = 1'b0;
    s_axi_awready  = 1'b0;
    s_axi_wready   = 1'b0;
    sram_cmd_valid = 1'b0;
    sram_cmd_wr_en = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ar) begin
          s_axi_arready = 1'b1;
          state_next    = READ;
        end else if (grant_aw) begin
          s_axi_awready = 1'b1;
          state_next    = WRITE;
        end
      end
      READ: begin
        sram_cmd_valid = 1'b1;
        if (sram_cmd_ready && beat_cnt == 8'd0) state_next = IDLE;
      end
      WRITE: begin
        sram_cmd_valid = s_axi_wvalid;
        sram_cmd_wr_en = 1'b1;
        s_axi_wready   = sram_cmd_ready;
        if (s_axi_wvalid && sram_cmd_ready && beat_cnt == 8'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_hs = sram_cmd_valid && sram_cmd_ready;
  assign r_hs   = s_axi_rvalid && s_axi_rready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      beat_cnt <= 8'd0;
      bid_q    <= '0;
      rid_q    <= '0;
      r_busy   <= 1'b0;
      r_cnt    <= 8'd0;
      bvalid_q <= 1'b0;
    end else begin
      state <= state_next;
      // R tracking runs independently of the command FSM; AR accept needs !r_busy so they never collide.
      if (r_hs) begin
        r_cnt <= r_cnt - 8'd1;
        if (r_cnt == 8'd0) r_busy <= 1'b0;
      end
      if (s_axi_arready) begin
        addr     <= SRAM_ADDR_WIDTH'(s_axi_araddr >> LSB);
        beat_cnt <= s_axi_arlen;
        r_busy   <= 1'b1;
        r_cnt    <= s_axi_arlen;
        rid_q    <= s_axi_arid;
      end else if (s_axi_awready) begin
        addr     <= SRAM_ADDR_WIDTH'(s_axi_awaddr >> LSB);
        beat_cnt <= s_axi_awlen;
        bid_q    <= s_axi_awid;
      end else if (cmd_hs) begin
        addr     <= addr + 1'b1;
        beat_cnt <= beat_cnt - 8'd1;
      end
      if (s_axi_bvalid && s_axi_bready) bvalid_q <= 1'b0;
      if (state == WRITE && cmd_hs && beat_cnt == 8'd0) bvalid_q <= 1'b1;
    end
  end

  assign sram_cmd_addr      = addr;
  assign sram_cmd_wr_data   = s_axi_wdata;
  assign sram_cmd_wr_strb   = s_axi_wstrb;
  assign s_axi_bvalid       = bvalid_q;
  assign s_axi_bid          = bid_q;
  assign s_axi_bresp        = 2'b00;
  assign s_axi_rvalid       = sram_resp_rd_valid && r_busy;
  assign sram_resp_rd_ready = s_axi_rready && r_busy;
  assign s_axi_rdata        = sram_resp_rd_data;
  assign s_axi_rid          = rid_q;
  assign s_axi_rresp        = 2'b00;
  assign s_axi_rlast        = r_busy && (r_cnt == 8'd0);
endmodule
